fp16_add_sched: RTL and testbench
=================================

FP16_ADD_SCHED -- requirements
Module: fp16_add_sched

Interface
REQ-001 Parameter SHIFT_PER_CYCLE, default 1, sets alignment bits shifted per ALIGN cycle; legal values are 1, 2 and 4.
REQ-002 The ports SHALL be as follows:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 holds an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req0_a, req0_b  in  16 each  requester 0 FP16 operands.
- req1_valid, req1_ready, req1_a, req1_b  as req0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumer accepts.
- rsp_id  out  1  requester that owns the result.
- rsp_sum  out  16  FP16 sum.
- rsp_ovf  out  1  exponent overflow or infinite input.
- busy  out  1  state is not IDLE.

Function
REQ-003 The block SHALL share one iterative positive-FP16 adder datapath between two requesters and process one operation at a time.
REQ-004 The FSM SHALL have five states: IDLE, ALIGN, ADD, NORM, DONE.
REQ-005 In IDLE, reqN_ready SHALL be combinational: high only for the granted requester whose valid is high; the handshake completes when valid and ready are both high.
REQ-006 Arbitration SHALL be round-robin: with a single valid requester, that requester is granted; with both valid, the requester not granted last is granted. last_grant resets to 1, so req0 wins the first tie.
REQ-007 On accept, the block SHALL latch the operands with sign bits ignored; the larger exponent becomes the result exponent. Significands SHALL be formed with the hidden 1 (11 bits), and the smaller one becomes the shift target. d = |ea - eb|.
REQ-008 If either exponent field is 0, that operand SHALL be treated as zero, the result is the other operand with sign 0, and ALIGN is skipped.
REQ-009 If either exponent field is 31, the result SHALL be 0x7C00 with rsp_ovf = 1, and ALIGN is skipped.
REQ-010 Exit from IDLE after accept SHALL go to ALIGN when the effective shift k = ceil(min(d,12)/SHIFT_PER_CYCLE) is greater than 0, and to ADD otherwise.
REQ-011 ALIGN SHALL right-shift the smaller significand by SHIFT_PER_CYCLE bits per cycle, without exceeding the remaining count, for exactly k cycles, then go to ADD. Shifted-out bits SHALL be truncated.
REQ-012 ADD SHALL form the 12-bit sum of the two 11-bit significands in one cycle, then go to NORM.
REQ-013 NORM behaviour SHALL depend on sum[11]:
- sum[11] = 1: mantissa = sum[10:1] and exponent + 1.
- sum[11] = 0: mantissa = sum[9:0].
- Exponent reaching 31: result 0x7C00 with rsp_ovf = 1.
NORM then goes to DONE.
REQ-014 DONE SHALL assert rsp_valid. rsp_sum, rsp_id and rsp_ovf SHALL stay stable until rsp_ready is high.
REQ-015 On the rsp_valid and rsp_ready handshake, the FSM SHALL return to IDLE; a new request can be accepted no earlier than the next cycle.
REQ-016 Latency: a handshake in cycle T SHALL give rsp_valid in cycle T + k + 3.
REQ-017 rsp_sum[15] SHALL always be 0.
REQ-018 Requests presented while busy SHALL be ignored, with ready low; the requester holds valid.

Reset
REQ-019 rst_n low SHALL asynchronously force the following, including during any ALIGN, ADD, NORM or DONE cycle:
- state = IDLE, last_grant = 1;
- rsp_valid = 0, rsp_sum = 0, rsp_id = 0, rsp_ovf = 0, busy = 0;
- req0_ready = 0 and req1_ready = 0;
- any in-flight operation discarded.
REQ-020 After rst_n is released, the first accept SHALL occur no earlier than the first rising clk edge with rst_n high.

Structure
REQ-021 Shared package fp16_pkg SHALL hold:
- the state enum;
- EXP_W = 5, MAN_W = 10;
- FP16_INF = 16'h7C00;
- MAX_ALIGN = 12.
REQ-022 One sub-module rr_arb2 SHALL implement the two-way round-robin grant and the last_grant register; the datapath and FSM stay in fp16_add_sched.

Verification
REQ-023 req0 with 0x3C00 + 0x3C00, SHIFT_PER_CYCLE = 1 -> rsp_sum 0x4000, rsp_ovf 0, rsp_id 0, rsp_valid at T+3.
REQ-024 req1 with 0x3C00 + 0x3800 -> rsp_sum 0x3E00, rsp_id 1, rsp_valid at T+4. The same pair with 0x3C00 + 0x1400 (d = 10) -> T+13 at S = 1 and T+6 at S = 4.
REQ-025 req0 with 0x7BFF + 0x7BFF -> rsp_sum 0x7C00, rsp_ovf 1. req0 with 0x0000 + 0xBC00 -> rsp_sum 0x3C00, rsp_valid at T+3.
REQ-026 Both requesters valid from reset, rsp_ready held high -> grants req0, then req1, then req0; each result carries the matching rsp_id.
REQ-027 rsp_ready held low for 5 cycles in DONE -> outputs stable and req ready low throughout; the release accepts the next request one cycle after the rsp handshake.
REQ-028 rst_n asserted in the 3rd ALIGN cycle of 0x3C00 + 0x2000 -> rsp_valid, busy and ready all 0 immediately; after release, req0 wins the next tie.

Source files
------------

// File: rtl/fp16_pkg.sv
// ============================================================================
// Module : fp16_pkg
// Brief  : Shared constants and FSM state encoding for the FP16 add scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp16_pkg;

    localparam int          EXP_W     = 5;
    localparam int          MAN_W     = 10;
    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam int          MAX_ALIGN = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant with last-grant history register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic r_last;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (update) begin
            r_last <= gnt[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp16_add_sched.sv
// ============================================================================
// Module : fp16_add_sched
// Brief  : Iterative positive FP16 adder shared between two requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp16_add_sched
    import fp16_pkg::*;
#(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_sum,
    output logic        rsp_ovf,
    output logic        busy
);

    localparam logic [3:0]       c_step   = 4'(SHIFT_PER_CYCLE);
    localparam logic [EXP_W-1:0] c_exp_max = '1;

    state_t            r_state, w_next;
    logic [1:0]        w_gnt;
    logic              w_idle, w_accept;
    logic [14:0]       w_a, w_b;
    logic [EXP_W-1:0]  w_ea, w_eb, w_d, w_exp_inc;
    logic              w_a_big, w_inf, w_zero, w_special;
    logic [3:0]        w_rem_init, w_step;
    logic [15:0]       w_special_res, w_norm_res;
    logic              w_norm_ovf;
    logic              w_unused;

    logic [MAN_W:0]    r_big, r_small;
    logic [EXP_W-1:0]  r_exp;
    logic [3:0]        r_rem;
    logic [MAN_W+1:0]  r_sum;
    logic              r_special, r_spec_ovf, r_id, r_rsp_ovf;
    logic [15:0]       r_spec_res, r_rsp_sum;

    assign w_unused = ^{req0_a[15], req0_b[15], req1_a[15], req1_b[15]};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .update (w_accept),
        .gnt    (w_gnt)
    );

    // Operand decode for the granted requester; sign bits are dropped here.
    assign w_a        = w_gnt[1] ? req1_a[14:0] : req0_a[14:0];
    assign w_b        = w_gnt[1] ? req1_b[14:0] : req0_b[14:0];
    assign w_ea       = w_a[14:10];
    assign w_eb       = w_b[14:10];
    assign w_a_big    = (w_ea >= w_eb);
    assign w_d        = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_rem_init = (w_d > 5'(MAX_ALIGN)) ? 4'(MAX_ALIGN) : w_d[3:0];
    assign w_inf      = (w_ea == c_exp_max) || (w_eb == c_exp_max);
    assign w_zero     = (w_ea == '0) || (w_eb == '0);
    assign w_special  = w_inf || w_zero;
    assign w_special_res = w_inf        ? FP16_INF :
                           (w_ea == '0) ? {1'b0, w_b} : {1'b0, w_a};

    assign w_step    = (r_rem < c_step) ? r_rem : c_step;
    assign w_exp_inc = r_exp + 1'b1;

    always_comb begin
        w_norm_res = {1'b0, r_exp, r_sum[MAN_W-1:0]};
        w_norm_ovf = 1'b0;
        if (r_special) begin
            w_norm_res = r_spec_res;
            w_norm_ovf = r_spec_ovf;
        end else if (r_sum[MAN_W+1]) begin
            if (w_exp_inc == c_exp_max) begin
                w_norm_res = FP16_INF;
                w_norm_ovf = 1'b1;
            end else begin
                w_norm_res = {1'b0, w_exp_inc, r_sum[MAN_W:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (!w_special && (w_rem_init != '0)) ? S_ALIGN : S_ADD;
            S_ALIGN: if (r_rem <= c_step) w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  w_next = S_DONE;
            S_DONE:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        w_idle     = (r_state == S_IDLE);
        req0_ready = rst_n && w_idle && w_gnt[0];
        req1_ready = rst_n && w_idle && w_gnt[1];
        rsp_valid  = (r_state == S_DONE);
        busy       = !w_idle;
    end

    assign w_accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_big      <= '0;
            r_small    <= '0;
            r_exp      <= '0;
            r_rem      <= '0;
            r_sum      <= '0;
            r_special  <= 1'b0;
            r_spec_ovf <= 1'b0;
            r_spec_res <= '0;
            r_id       <= 1'b0;
            r_rsp_sum  <= '0;
            r_rsp_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_id       <= w_gnt[1];
                    r_big      <= w_a_big ? {1'b1, w_a[9:0]} : {1'b1, w_b[9:0]};
                    r_small    <= w_a_big ? {1'b1, w_b[9:0]} : {1'b1, w_a[9:0]};
                    r_exp      <= w_a_big ? w_ea : w_eb;
                    r_rem      <= w_special ? 4'd0 : w_rem_init;
                    r_special  <= w_special;
                    r_spec_ovf <= w_inf;
                    r_spec_res <= w_special_res;
                end
                S_ALIGN: begin
                    r_small <= r_small >> w_step;
                    r_rem   <= r_rem - w_step;
                end
                S_ADD:  r_sum <= {1'b0, r_big} + {1'b0, r_small};
                S_NORM: begin
                    r_rsp_sum <= w_norm_res;
                    r_rsp_ovf <= w_norm_ovf;
                end
                default: ;
            endcase
        end
    end

    assign rsp_sum = r_rsp_sum;
    assign rsp_ovf = r_rsp_ovf;
    assign rsp_id  = r_id;

endmodule

`default_nettype wire

// File: tb/tb_fp16_add_sched.sv
// ============================================================================
// Module : tb_fp16_add_sched
// Brief  : Scoreboard bench for fp16_add_sched (S=1 main DUT, S=4 latency DUT).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp16_add_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
    logic [15:0] rsp_sum;

    logic        d4_req0_valid, d4_req0_ready, d4_req1_valid, d4_req1_ready;
    logic [15:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
    logic        d4_rsp_valid, d4_rsp_ready, d4_rsp_id, d4_rsp_ovf, d4_busy;
    logic [15:0] d4_rsp_sum;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
        logic        id;
        int          k;
        int          due;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    bit   m_last = 1'b1;
    bit   prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp16_add_sched #(.SHIFT_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    fp16_add_sched #(.SHIFT_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d4_req0_valid), .req0_ready(d4_req0_ready), .req0_a(d4_req0_a), .req0_b(d4_req0_b),
        .req1_valid(d4_req1_valid), .req1_ready(d4_req1_ready), .req1_a(d4_req1_a), .req1_b(d4_req1_b),
        .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_id(d4_rsp_id),
        .rsp_sum(d4_rsp_sum), .rsp_ovf(d4_rsp_ovf), .busy(d4_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole alignment shift applied at once, then normalise.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int s);
        exp_t r;
        int ea, eb, ebig, d, sh, mb, ms, tot, e;
        r.sum = 16'h0; r.ovf = 1'b0; r.id = 1'b0; r.k = 0; r.due = 0;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if (ea == 31 || eb == 31) begin
            r.sum = 16'h7C00; r.ovf = 1'b1;
        end else if (ea == 0) begin
            r.sum = {1'b0, b[14:0]};
        end else if (eb == 0) begin
            r.sum = {1'b0, a[14:0]};
        end else begin
            if (ea >= eb) begin
                ebig = ea; d = ea - eb; mb = 1024 + int'(a[9:0]); ms = 1024 + int'(b[9:0]);
            end else begin
                ebig = eb; d = eb - ea; mb = 1024 + int'(b[9:0]); ms = 1024 + int'(a[9:0]);
            end
            sh  = (d > 12) ? 12 : d;
            tot = mb + (ms >> sh);
            e   = ebig;
            if (tot >= 2048) begin
                e++; tot = tot >> 1;
            end
            if (e >= 31) begin
                r.sum = 16'h7C00; r.ovf = 1'b1;
            end else begin
                r.sum = {1'b0, 5'(e), 10'(tot % 1024)};
            end
            r.k = (sh + s - 1) / s;
        end
        return r;
    endfunction

    // Monitor: grant model, handshake capture, response scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   e0, e1, id;
        if (rst_n) begin
            if (!busy) begin
                e0 = req0_valid && (!req1_valid || m_last);
                e1 = req1_valid && (!req0_valid || !m_last);
                chk("grant", {30'd0, req1_ready, req0_ready}, {30'd0, e1, e0});
            end else begin
                chk("rdy_busy", {30'd0, req1_ready, req0_ready}, 32'd0);
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                id    = req1_valid && req1_ready;
                e     = id ? model(req1_a, req1_b, 1) : model(req0_a, req0_b, 1);
                e.id  = id;
                e.due = cyc + e.k + 3;
                sb.push_back(e);
                grant_log.push_back(id);
                m_last = id;
                hs_cnt++;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    if (!prev_valid) chk("sb_latency", cyc, sb[0].due);
                    chk("sb_sum", {16'd0, rsp_sum}, {16'd0, sb[0].sum});
                    chk("sb_id",  {31'd0, rsp_id},  {31'd0, sb[0].id});
                    chk("sb_ovf", {31'd0, rsp_ovf}, {31'd0, sb[0].ovf});
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            prev_valid = rsp_valid && !rsp_ready;
        end else begin
            prev_valid = 1'b0;
            m_last     = 1'b1;
            sb.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            tick(); n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_dir(input string tag, input bit id, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] es, input bit eo, input int elat);
        int n = 0;
        int t0;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 50) begin tick(); n++; end
        if (n >= 50) chk({tag, "_accept"}, 32'd0, 32'd1);
        t0 = cyc;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin tick(); n++; end
        chk({tag, "_lat"}, cyc - t0, elat);
        chk({tag, "_sum"}, {16'd0, rsp_sum}, {16'd0, es});
        chk({tag, "_ovf"}, {31'd0, rsp_ovf}, {31'd0, eo});
        chk({tag, "_id"},  {31'd0, rsp_id},  {31'd0, id});
        tick();
    endtask

    initial begin
        int          n, t0;
        exp_t        e;
        logic [15:0] a, b;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00;
        req1_valid = 1'b1; req1_a = 16'h3C00; req1_b = 16'h3800;
        d4_req0_valid = 1'b0; d4_req0_a = 16'h0; d4_req0_b = 16'h0;
        d4_req1_valid = 1'b0; d4_req1_a = 16'h0; d4_req1_b = 16'h0;
        d4_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_out",   {15'd0, rsp_id, rsp_ovf, rsp_sum}, 32'd0);
        #3 rst_n = 1'b1;

        // Both requesters valid from reset: req0, req1, req0.
        n = 0;
        while (hs_cnt < 3 && n < 100) begin tick(); n++; end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        chk("rr_count", grant_log.size(), 32'd3);
        if (grant_log.size() >= 3) begin
            chk("rr_g0", {31'd0, grant_log[0]}, 32'd0);
            chk("rr_g1", {31'd0, grant_log[1]}, 32'd1);
            chk("rr_g2", {31'd0, grant_log[2]}, 32'd0);
        end

        run_dir("one_one",   1'b0, 16'h3C00, 16'h3C00, 16'h4000, 1'b0, 3);
        run_dir("one_half",  1'b1, 16'h3C00, 16'h3800, 16'h3E00, 1'b0, 4);
        run_dir("d10_s1",    1'b1, 16'h3C00, 16'h1400, 16'h3C01, 1'b0, 13);
        run_dir("exp_ovf",   1'b0, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 3);
        run_dir("zero_op",   1'b0, 16'h0000, 16'hBC00, 16'h3C00, 1'b0, 3);
        run_dir("inf_in",    1'b0, 16'h7C00, 16'h3C00, 16'h7C00, 1'b1, 3);
        run_dir("d14_clamp", 1'b1, 16'h3C00, 16'h0400, 16'h3C00, 1'b0, 15);

        // S=4 instance: d=10 takes three alignment cycles.
        d4_req1_valid = 1'b1; d4_req1_a = 16'h3C00; d4_req1_b = 16'h1400;
        #1;
        n = 0;
        while (!d4_req1_ready && n < 50) begin tick(); n++; end
        t0 = cyc;
        tick();
        d4_req1_valid = 1'b0;
        n = 0;
        while (!d4_rsp_valid && n < 100) begin tick(); n++; end
        chk("s4_lat", cyc - t0, 32'd6);
        chk("s4_sum", {16'd0, d4_rsp_sum}, 32'h3C01);
        chk("s4_id",  {31'd0, d4_rsp_id}, 32'd1);
        tick();

        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            e = model(a, b, 1);
            run_dir("rand", i[0], a, b, e.sum, e.ovf, e.k + 3);
        end

        // Consumer stalls five cycles in DONE.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00;
        #1;
        n = 0;
        while (!req0_ready && n < 50) begin tick(); n++; end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h3C00; req1_b = 16'h3800;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_sum",   {16'd0, rsp_sum}, 32'h4000);
            chk("hold_ready", {31'd0, req1_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("hold_release", {31'd0, rsp_valid}, 32'd1);
        tick();
        chk("next_accept", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        drain();

        // Reset in the third ALIGN cycle of a d=7 operation.
        req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h2000;
        #1;
        n = 0;
        while (!req0_ready && n < 50) begin tick(); n++; end
        tick();
        req1_valid = 1'b1; req1_a = 16'h3800; req1_b = 16'h3800;
        tick();
        tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        #1;
        chk("post_rst_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
